dpram_port_arbiter: RTL

- Sequencer and arbiter for one port of the team's dual-port RAM; the other RAM port stays free for video or sound fetch.
- Shares that port between a ROM download writer (ioctl path) and two round-robin requesters (e.g. CPU and DMA).
- Includes a clear engine that sweeps the whole array with a fixed value.
- All RAM-side outputs are registered and drive the RAM's address/data/enable/wren inputs directly.

---
 rtl/dpram_port_arbiter_pkg.sv | 13 +
 rtl/dpram_port_arbiter_rr_arbiter2.sv | 28 ++
 rtl/dpram_port_arbiter.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/dpram_port_arbiter_pkg.sv
// Shared encodings for the dual-port RAM port sequencer: FSM states and requester ids.
package dpram_port_arbiter_pkg;

  typedef enum logic [1:0] {
    S_RUN   = 2'd0,
    S_CLEAR = 2'd1,
    S_DL    = 2'd2
  } state_t;

  localparam logic REQ0 = 1'b0;
  localparam logic REQ1 = 1'b1;

endpackage

// File: rtl/dpram_port_arbiter_rr_arbiter2.sv
// Two-way round-robin arbiter; combinational grant, remembers the last winner.
module rr_arbiter2
  import dpram_port_arbiter_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic       enable,
  input  logic [1:0] req,
  output logic [1:0] gnt
);

  logic rr_last;

  always_comb begin
    gnt = 2'b00;
    if (enable) begin
      // On a tie the requester that did not win last time goes first
      if (req == 2'b11) gnt = (rr_last == REQ1) ? 2'b01 : 2'b10;
      else              gnt = req;
    end
  end

  always_ff @(posedge clock) begin
    if (reset)     rr_last <= REQ1;
    else if (|gnt) rr_last <= gnt[1];
  end

endmodule

// File: rtl/dpram_port_arbiter.sv
// Owns one RAM port: download writer, clear sweep and two round-robin requesters,
// with registered RAM-side outputs and a 2-cycle read-return tag pipeline.
module dpram_port_arbiter
  import dpram_port_arbiter_pkg::*;
#(
  parameter int                    data_width    = 8,
  parameter int                    address_width = 8,
  parameter logic [data_width-1:0] clear_value   = '0
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     dl_active,
  input  logic                     dl_wr,
  input  logic [address_width-1:0] dl_addr,
  input  logic [data_width-1:0]    dl_data,
  input  logic                     clear_start,
  output logic                     clear_busy,
  output logic                     clear_done,
  input  logic                     req0_req,
  input  logic                     req0_we,
  input  logic [address_width-1:0] req0_addr,
  input  logic [data_width-1:0]    req0_wdata,
  output logic                     req0_gnt,
  output logic                     req0_rvalid,
  output logic [data_width-1:0]    req0_rdata,
  input  logic                     req1_req,
  input  logic                     req1_we,
  input  logic [address_width-1:0] req1_addr,
  input  logic [data_width-1:0]    req1_wdata,
  output logic                     req1_gnt,
  output logic                     req1_rvalid,
  output logic [data_width-1:0]    req1_rdata,
  output logic [address_width-1:0] ram_address,
  output logic [data_width-1:0]    ram_data,
  output logic                     ram_enable,
  output logic                     ram_wren,
  input  logic [data_width-1:0]    ram_q
);

  // One extra counter bit keeps the terminal compare away from wrap-around
  localparam logic [address_width:0] LAST = {1'b0, {address_width{1'b1}}};

  state_t                   state, state_nxt;
  logic [address_width:0]   clr_cnt;
  logic [1:0]               gnt;
  logic                     arb_en;
  logic                     clear_last;
  logic                     issue_vld, issue_we, issue_rd, issue_id;
  logic [address_width-1:0] issue_addr;
  logic [data_width-1:0]    issue_data;
  logic                     rd_vld_p0, rd_id_p0;
  logic                     rd_vld_p1, rd_id_p1;

  assign arb_en     = (state == S_RUN) && !dl_active && !reset;
  assign clear_last = (state == S_CLEAR) && !dl_active && (clr_cnt == LAST);

  rr_arbiter2 u_arb (
    .clock  (clock),
    .reset  (reset),
    .enable (arb_en),
    .req    ({req1_req, req0_req}),
    .gnt    (gnt)
  );

  always_ff @(posedge clock) begin
    if (reset) state <= S_RUN;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (dl_active) begin
      state_nxt = S_DL;
    end else begin
      case (state)
        S_RUN:   if (clear_start) state_nxt = S_CLEAR;
        S_CLEAR: if (clr_cnt == LAST) state_nxt = S_RUN;
        S_DL:    state_nxt = S_RUN;
        default: state_nxt = S_RUN;
      endcase
    end
  end

  // Select the single access to issue this cycle: download, then sweep, then requesters
  always_comb begin
    issue_vld  = 1'b0;
    issue_we   = 1'b0;
    issue_rd   = 1'b0;
    issue_id   = REQ0;
    issue_addr = '0;
    issue_data = '0;
    if (dl_active) begin
      issue_vld  = dl_wr;
      issue_we   = 1'b1;
      issue_addr = dl_addr;
      issue_data = dl_data;
    end else if (state == S_CLEAR) begin
      issue_vld  = 1'b1;
      issue_we   = 1'b1;
      issue_addr = clr_cnt[address_width-1:0];
      issue_data = clear_value;
    end else if (gnt[0]) begin
      issue_vld  = 1'b1;
      issue_we   = req0_we;
      issue_rd   = !req0_we;
      issue_id   = REQ0;
      issue_addr = req0_addr;
      issue_data = req0_wdata;
    end else if (gnt[1]) begin
      issue_vld  = 1'b1;
      issue_we   = req1_we;
      issue_rd   = !req1_we;
      issue_id   = REQ1;
      issue_addr = req1_addr;
      issue_data = req1_wdata;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      clr_cnt     <= '0;
      clear_done  <= 1'b0;
      ram_enable  <= 1'b0;
      ram_wren    <= 1'b0;
      ram_address <= '0;
      ram_data    <= '0;
      rd_vld_p0   <= 1'b0;
      rd_id_p0    <= REQ0;
      rd_vld_p1   <= 1'b0;
      rd_id_p1    <= REQ0;
    end else begin
      if (state == S_RUN && state_nxt == S_CLEAR) clr_cnt <= '0;
      else if (state == S_CLEAR && !dl_active)     clr_cnt <= clr_cnt + 1'b1;
      clear_done <= clear_last;
      // p0: access registered onto the RAM port
      ram_enable <= issue_vld;
      ram_wren   <= issue_vld && issue_we;
      if (issue_vld) begin
        ram_address <= issue_addr;
        ram_data    <= issue_data;
      end
      rd_vld_p0 <= issue_rd;
      rd_id_p0  <= issue_id;
      // p1: RAM has sampled the address, ram_q valid this cycle
      rd_vld_p1 <= rd_vld_p0;
      rd_id_p1  <= rd_id_p0;
    end
  end

  assign clear_busy  = (state == S_CLEAR);
  assign req0_gnt    = gnt[0];
  assign req1_gnt    = gnt[1];
  assign req0_rvalid = rd_vld_p1 && (rd_id_p1 == REQ0);
  assign req1_rvalid = rd_vld_p1 && (rd_id_p1 == REQ1);
  assign req0_rdata  = ram_q;
  assign req1_rdata  = ram_q;

endmodule
